gol_sequencer: RTL and testbench

Control FSM for the 16x16 Game-of-Life grid register.
- Turns debounced single-cycle user pulses into the grid's edit/update controls: cursor moves, cell toggles, run/pause, single step and a full-grid clear sweep.
- In run mode, paces generations with a programmable tick divider and counts generations for the display path.
- Sits between the input debouncers and the grid/next-state datapath.

---
 rtl/gol_sequencer.sv | 164 ++++++++++++++++
 tb/tb_gol_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gol_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gol_sequencer
// Purpose  : Control FSM for the Game-of-Life grid register. Converts
//            one-cycle user pulses into cursor moves, cell toggles,
//            run/pause pacing, single steps and a full-grid clear sweep.
// Revision : 1.0 - initial release
// ============================================================================
module gol_sequencer #(
  parameter int GRID_N   = 16,
  parameter int TICK_DIV = 25000000,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_toggle,
  input  logic             btn_run,
  input  logic             btn_step,
  input  logic             btn_clear,
  input  logic             cur_cell,
  output logic [7:0]       row_select,
  output logic [7:0]       col_select,
  output logic             set_initial,
  output logic             new_state,
  output logic             enable_update,
  output logic             running,
  output logic             clearing,
  output logic [CNT_W-1:0] gen_count
);

  localparam int IDX_W  = (GRID_N > 1) ? $clog2(GRID_N) : 1;
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam logic [IDX_W-1:0]  IDX_MAX   = IDX_W'(GRID_N - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_EDIT  = 2'd0,
    S_RUN   = 2'd1,
    S_STEP  = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  row_q, col_q, row_d, col_d;
  logic [IDX_W-1:0]  srow_q, scol_q, srow_d, scol_d;
  logic [TICK_W-1:0] tick_q;

  function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] v);
    return (v == IDX_MAX) ? '0 : v + IDX_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] dec_wrap(input logic [IDX_W-1:0] v);
    return (v == '0) ? IDX_MAX : v - IDX_W'(1);
  endfunction

  // Next cursor position (opposing moves cancel per axis) and next sweep cell.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (btn_up && !btn_down)        row_d = dec_wrap(row_q);
    else if (btn_down && !btn_up)   row_d = inc_wrap(row_q);
    if (btn_left && !btn_right)     col_d = dec_wrap(col_q);
    else if (btn_right && !btn_left) col_d = inc_wrap(col_q);
    scol_d = inc_wrap(scol_q);
    srow_d = (scol_q == IDX_MAX) ? inc_wrap(srow_q) : srow_q;
  end

  // Main FSM; every output is a register updated alongside the state so that
  // strobes coincide with the state they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_EDIT;
      row_q         <= '0;
      col_q         <= '0;
      srow_q        <= '0;
      scol_q        <= '0;
      tick_q        <= '0;
      row_select    <= '0;
      col_select    <= '0;
      set_initial   <= 1'b0;
      new_state     <= 1'b0;
      enable_update <= 1'b0;
      running       <= 1'b0;
      clearing      <= 1'b0;
      gen_count     <= '0;
    end else begin
      set_initial   <= 1'b0;
      new_state     <= 1'b0;
      enable_update <= 1'b0;
      if ((state_q == S_EDIT || state_q == S_RUN) && btn_clear) begin
        // Clear outranks everything; the first sweep cell is written at once.
        state_q     <= S_CLEAR;
        srow_q      <= '0;
        scol_q      <= '0;
        row_select  <= '0;
        col_select  <= '0;
        set_initial <= 1'b1;
        running     <= 1'b0;
        clearing    <= 1'b1;
      end else begin
        case (state_q)
          S_EDIT: begin
            if (btn_run) begin
              state_q <= S_RUN;
              tick_q  <= '0;
              running <= 1'b1;
            end else if (btn_step) begin
              state_q       <= S_STEP;
              enable_update <= 1'b1;
              gen_count     <= gen_count + CNT_W'(1);
            end else if (btn_toggle) begin
              set_initial <= 1'b1;
              new_state   <= ~cur_cell;
            end else begin
              row_q      <= row_d;
              col_q      <= col_d;
              row_select <= 8'(row_d);
              col_select <= 8'(col_d);
            end
          end
          S_RUN: begin
            if (btn_run) begin
              // Pause wins over a tick expiring in the same cycle.
              state_q <= S_EDIT;
              tick_q  <= '0;
              running <= 1'b0;
            end else if (tick_q == TICK_LAST) begin
              tick_q        <= '0;
              enable_update <= 1'b1;
              gen_count     <= gen_count + CNT_W'(1);
            end else begin
              tick_q <= tick_q + TICK_W'(1);
            end
          end
          S_STEP: begin
            state_q <= S_EDIT;
          end
          S_CLEAR: begin
            if (srow_q == IDX_MAX && scol_q == IDX_MAX) begin
              state_q    <= S_EDIT;
              clearing   <= 1'b0;
              gen_count  <= '0;
              row_select <= 8'(row_q);
              col_select <= 8'(col_q);
            end else begin
              srow_q      <= srow_d;
              scol_q      <= scol_d;
              row_select  <= 8'(srow_d);
              col_select  <= 8'(scol_d);
              set_initial <= 1'b1;
            end
          end
          default: state_q <= S_EDIT;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gol_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gol_sequencer
// Purpose  : Scoreboard bench for gol_sequencer (TICK_DIV=4). Stimulus pushes
//            expected grid writes and generation strobes; a monitor pops and
//            compares them whenever the DUT raises set_initial/enable_update.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gol_sequencer;

  localparam int GRID_N = 16;
  localparam int TDIV   = 4;
  localparam int CNT_W  = 16;

  localparam logic [7:0] B_UP = 8'h01, B_DOWN = 8'h02, B_LEFT = 8'h04,
                         B_RIGHT = 8'h08, B_TOG = 8'h10, B_STEP = 8'h20,
                         B_RUN = 8'h40, B_CLR = 8'h80;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0] btn = '0;
  logic cur_cell = 1'b0;
  logic [7:0] row_select, col_select;
  logic set_initial, new_state, enable_update, running, clearing;
  logic [CNT_W-1:0] gen_count;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct { int cyc; int row; int col; int val; } wr_t;
  typedef struct { int cyc; int gen; } st_t;
  wr_t wr_q[$];
  st_t st_q[$];

  gol_sequencer #(.GRID_N(GRID_N), .TICK_DIV(TDIV), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .btn_up(btn[0]), .btn_down(btn[1]), .btn_left(btn[2]), .btn_right(btn[3]),
    .btn_toggle(btn[4]), .btn_step(btn[5]), .btn_run(btn[6]), .btn_clear(btn[7]),
    .cur_cell(cur_cell),
    .row_select(row_select), .col_select(col_select),
    .set_initial(set_initial), .new_state(new_state),
    .enable_update(enable_update), .running(running), .clearing(clearing),
    .gen_count(gen_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called at a negedge: drive the mask across exactly one rising edge.
  task automatic press(input logic [7:0] m);
    btn = m;
    @(negedge clk);
    btn = '0;
  endtask

  task automatic push_st(input int c, input int g);
    st_t s;
    s.cyc = c; s.gen = g;
    st_q.push_back(s);
  endtask

  task automatic push_wr(input int c, input int r, input int col, input int v);
    wr_t w;
    w.cyc = c; w.row = r; w.col = col; w.val = v;
    wr_q.push_back(w);
  endtask

  task automatic push_sweep(input int c);
    for (int k = 0; k < GRID_N * GRID_N; k++)
      push_wr(c + k, k / GRID_N, k % GRID_N, 0);
  endtask

  // Monitor: every strobe the DUT presents must match the head of its queue.
  wr_t mw;
  st_t ms;
  always @(negedge clk) begin
    if (reset) begin
      if (set_initial && enable_update) begin
        checks++;
        failures++;
        $display("FAIL strobe_overlap set_initial=1 enable_update=1 required=never_both cyc=%0d", cyc);
      end
      if (set_initial) begin
        if (wr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write row=%0d col=%0d val=%0d expected=no_write cyc=%0d",
                   row_select, col_select, new_state, cyc);
        end else begin
          mw = wr_q.pop_front();
          chk("wr_cyc", cyc, mw.cyc);
          chk("wr_row", int'(row_select), mw.row);
          chk("wr_col", int'(col_select), mw.col);
          chk("wr_val", int'(new_state), mw.val);
        end
      end
      if (enable_update) begin
        if (st_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe gen=%0d expected=no_strobe cyc=%0d", gen_count, cyc);
        end else begin
          ms = st_q.pop_front();
          chk("st_cyc", cyc, ms.cyc);
          chk("st_gen", int'(gen_count), ms.gen);
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_row"}, int'(row_select), 0);
    chk({tag, "_col"}, int'(col_select), 0);
    chk({tag, "_set"}, int'(set_initial), 0);
    chk({tag, "_new"}, int'(new_state), 0);
    chk({tag, "_upd"}, int'(enable_update), 0);
    chk({tag, "_run"}, int'(running), 0);
    chk({tag, "_clr"}, int'(clearing), 0);
    chk({tag, "_gen"}, int'(gen_count), 0);
  endtask

  initial begin
    int e;
    int c;
    // ---- reset and cursor wrap ----
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);
    press(B_UP);
    chk("up_wrap_row", int'(row_select), 15);
    chk("up_wrap_col", int'(col_select), 0);
    press(B_LEFT);
    chk("left_wrap_col", int'(col_select), 15);
    press(B_RIGHT);
    chk("right_wrap_col", int'(col_select), 0);
    press(B_UP | B_DOWN);
    chk("updown_cancel_row", int'(row_select), 15);
    press(B_DOWN);
    chk("down_wrap_row", int'(row_select), 0);
    for (int i = 0; i < 8; i++) press(B_DOWN | B_RIGHT);
    chk("cursor88_row", int'(row_select), 8);
    chk("cursor88_col", int'(col_select), 8);

    // ---- toggle writes ----
    cur_cell = 1'b0;
    push_wr(cyc + 1, 8, 8, 1);
    press(B_TOG);
    @(negedge clk);
    cur_cell = 1'b1;
    push_wr(cyc + 1, 8, 8, 0);
    press(B_TOG);
    @(negedge clk);
    cur_cell = 1'b0;

    // ---- run with TICK_DIV=4, pause at cycle 13 ----
    e = cyc + 1;
    push_st(e + 4, 1);
    push_st(e + 8, 2);
    push_st(e + 12, 3);
    press(B_RUN);
    chk("run_running", int'(running), 1);
    wait_to(e + 12);
    press(B_RUN);
    chk("pause_running", int'(running), 0);
    chk("pause_gen", int'(gen_count), 3);
    repeat (8) @(negedge clk);

    // ---- single steps ----
    push_st(cyc + 1, 4);
    press(B_STEP);
    repeat (2) @(negedge clk);
    push_st(cyc + 1, 5);
    press(B_STEP);
    repeat (2) @(negedge clk);
    chk("step_gen", int'(gen_count), 5);

    // ---- step/toggle/move ignored in RUN ----
    e = cyc + 1;
    push_st(e + 4, 6);
    press(B_RUN);
    wait_to(e + 1);
    press(B_STEP);
    press(B_TOG | B_UP);
    wait_to(e + 5);
    press(B_RUN);
    chk("run_ignore_row", int'(row_select), 8);
    chk("run_ignore_gen", int'(gen_count), 6);

    // ---- pause exactly on the expiring tick: no strobe ----
    e = cyc + 1;
    press(B_RUN);
    wait_to(e + 3);
    press(B_RUN);
    chk("pause_edge_gen", int'(gen_count), 6);
    repeat (6) @(negedge clk);

    // ---- clear sweep from RUN (clear lands on an expiring tick) ----
    e = cyc + 1;
    push_st(e + 4, 7);
    press(B_RUN);
    wait_to(e + 7);
    c = cyc + 1;
    push_sweep(c);
    press(B_CLR);
    chk("clear_clearing", int'(clearing), 1);
    chk("clear_running", int'(running), 0);
    wait_to(c + 255);
    chk("clear_last_clearing", int'(clearing), 1);
    chk("clear_hold_gen", int'(gen_count), 7);
    wait_to(c + 256);
    chk("clear_done_clearing", int'(clearing), 0);
    chk("clear_done_gen", int'(gen_count), 0);
    chk("clear_done_row", int'(row_select), 8);
    chk("clear_done_col", int'(col_select), 8);
    repeat (3) @(negedge clk);

    // ---- clear+toggle together, then reset mid-sweep ----
    push_st(cyc + 1, 1);
    press(B_STEP);
    repeat (2) @(negedge clk);
    c = cyc + 1;
    push_sweep(c);
    press(B_CLR | B_TOG);
    wait_to(c + 100);
    #2;
    reset = 1'b0;
    wr_q.delete();
    #1;
    chk_all_zero("midreset");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    press(B_DOWN);
    chk("post_reset_row", int'(row_select), 1);
    chk("post_reset_col", int'(col_select), 0);
    repeat (4) @(negedge clk);

    chk("wr_queue_empty", wr_q.size(), 0);
    chk("st_queue_empty", st_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
